conv_window_feeder: RTL and testbench
=====================================

# conv_window_feeder

Streaming 3x3 window generator that feeds the 3x3 convolution datapath. It accepts one raster-order pixel per handshake and buffers the two previous image rows in line buffers. For every pixel that completes a full 3x3 neighbourhood (no padding) it presents a registered 3x3 window, using valid/ready handshakes on both input and output. It sits between the frame source (DMA or test stream) and the convolution core's `i_data` input.

## Interface
- DATA_WIDTH, 4, pixel width in bits; must match the convolution core.
- IMG_WIDTH, 8, pixels per row; must be >= 3.
- IMG_HEIGHT, 8, rows per frame; must be >= 3.

- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  input pixel valid.
- o_ready  out  1  feeder can accept a pixel this cycle.
- i_pixel  in  DATA_WIDTH  pixel value, raster order (row-major, column 0 first).
- o_valid  out  1  o_window holds a valid window.
- i_ready  in  1  downstream accepts the window this cycle.
- o_window  out  DATA_WIDTH x [0:2][0:2]  window. [0][*] is the oldest row (r-2), [2][*] the newest. [*][0] is the oldest column (c-2). [2][2] is the newest pixel.
- o_last  out  1  qualifies o_window as the bottom-right window of the frame; valid only while o_valid.

## Operation
- Input accept: a pixel is accepted when i_valid && o_ready.
- o_ready = !o_valid || i_ready. This is combinational from i_ready and is the same for every pixel, whether or not it produces a window.
- Counters: col runs 0..IMG_WIDTH-1 and row runs 0..IMG_HEIGHT-1, both tracking the position of the next pixel. On accept, col increments; at IMG_WIDTH-1 it wraps to 0 and row increments. At row IMG_HEIGHT-1 / col IMG_WIDTH-1, both wrap to 0 and a new frame starts with no idle cycle.
- Line buffers: two IMG_WIDTH-deep row buffers, indexed by col.
  - On accept, read line0[col] (row r-1) and line1[col] (row r-2).
  - Write line0[col] <= i_pixel and line1[col] <= old line0[col].
  - Shift the three column values {line1, line0, i_pixel} into a 3x3 shift register.
- FSM:
  - S_FILL while row < 2; no windows are emitted.
  - Move to S_STREAM on accepting the last pixel of row 1.
  - S_STREAM emits a window for each accepted pixel with col >= 2.
  - Move back to S_FILL on accepting the last pixel of the frame.
- Window emit: on an accepting edge in S_STREAM with col >= 2, load o_window from the updated shift register, set o_valid, and set o_last if the accepted pixel is (IMG_HEIGHT-1, IMG_WIDTH-1).
- Output hold: when o_valid && !i_ready, o_window and o_last hold and no pixel is accepted.
- Output drain: o_valid clears on the edge where i_ready is high, unless a new window loads on that same edge.
- Windows per frame: (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- The shift register does not reset at row start. Columns 0-1 of a row only refill it, so stale data is never emitted.
- Values pass through unmodified; there is no arithmetic on pixel data.

## Timing
- Reset values: o_valid=0, o_last=0, o_window=all zeros, o_ready=1, row=col=0, FSM=S_FILL. Line buffer contents are not reset and are don't-care.
- Latency: o_valid rises one cycle after the accept edge of the window's newest pixel.
- Throughput: one pixel per cycle and one window per cycle when i_valid and i_ready stay high.
- Simultaneous output handshake and new window on the same edge: the new window replaces the old one and o_valid stays 1.
- Reset mid-frame: all state returns to reset values on the next edge. The in-flight window is dropped, and the next accepted pixel is treated as (0,0).
- i_pixel is ignored when no accept occurs.

## Configuration
- CONV_FEEDER_FRAME_CNT_EN:
  - When defined, adds port `o_frame_cnt out 16`. It resets to 0 and increments on the edge where the o_last window is handshaken (o_valid && o_last && i_ready), wrapping 0xFFFF -> 0.
  - When undefined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Basic window (IMG_WIDTH=IMG_HEIGHT=4), pixels 0..15 streamed with i_ready=1 -> exactly 4 windows, in this order:
  - [[0,1,2],[4,5,6],[8,9,10]]
  - [[1,2,3],[5,6,7],[9,10,11]]
  - [[4,5,6],[8,9,10],[12,13,14]]
  - [[5,6,7],[9,10,11],[13,14,15]], with o_last=1
  - o_last=0 on the first three.
- Latency: pixel 10 accepted at edge N -> o_valid=1 after edge N, window as above.
- Backpressure: hold i_ready=0 for 5 cycles after the first window -> o_ready=0, the window is stable, and no pixel is lost. Release -> the remaining 3 windows arrive correct.
- Back-to-back frames: stream the 0..15 frame twice with no gap -> 8 windows, second frame identical to the first, and o_last on windows 4 and 8.
- Reset mid-frame: assert i_rst_n=0 for one cycle after pixel 7 -> o_valid=0. A fresh 0..15 frame then yields the 4 basic windows.
- With CONV_FEEDER_FRAME_CNT_EN: three frames with random i_ready stalls -> o_frame_cnt=3, and reset returns it to 0.

Source files
------------

// File: rtl/conv_window_feeder.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift register, registered output.
// Optional frame counter port o_frame_cnt when CONV_FEEDER_FRAME_CNT_EN is defined.
module conv_window_feeder #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned IMG_WIDTH  = 8,
    parameter int unsigned IMG_HEIGHT = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    input  logic [DATA_WIDTH-1:0]                  i_pixel,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic [0:2][0:2][DATA_WIDTH-1:0]        o_window,
    output logic                                   o_last
`ifdef CONV_FEEDER_FRAME_CNT_EN
    ,
    output logic [15:0]                            o_frame_cnt
`endif
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);

    localparam logic [0:0] S_FILL   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    typedef logic [0:2][0:2][DATA_WIDTH-1:0] window_t;

    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic [0:0]            state_q;
    logic [DATA_WIDTH-1:0] line0_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] line1_q [IMG_WIDTH];
    window_t               shift_q;
    window_t               shift_d;

    logic                  accept;
    logic                  col_last;
    logic                  row_last;
    logic                  frame_last;
    logic                  emit;
    logic [DATA_WIDTH-1:0] rd0;
    logic [DATA_WIDTH-1:0] rd1;

    assign o_ready    = !o_valid || i_ready;
    assign accept     = i_valid && o_ready;
    assign col_last   = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last   = (row_q == RW'(IMG_HEIGHT - 1));
    assign frame_last = col_last && row_last;
    assign rd0        = line0_q[col_q];
    assign rd1        = line1_q[col_q];
    assign emit       = accept && (state_q == S_STREAM) && (col_q >= CW'(2));

    // Shift left by one column; the new right column is {row r-2, row r-1, row r}.
    always_comb begin
        shift_d = shift_q;
        for (int r = 0; r < 3; r++) begin
            shift_d[r][0] = shift_q[r][1];
            shift_d[r][1] = shift_q[r][2];
        end
        shift_d[0][2] = rd1;
        shift_d[1][2] = rd0;
        shift_d[2][2] = i_pixel;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            state_q  <= S_FILL;
            shift_q  <= '0;
            o_window <= '0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
        end else begin
            if (accept) begin
                shift_q <= shift_d;
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
                if (state_q == S_FILL && row_q == RW'(1) && col_last) begin
                    state_q <= S_STREAM;
                end else if (state_q == S_STREAM && frame_last) begin
                    state_q <= S_FILL;
                end
            end
            if (emit) begin
                o_window <= shift_d;
                o_valid  <= 1'b1;
                o_last   <= frame_last;
            end else if (i_ready) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
        end
    end

    // Line buffers are not reset; columns 0-1 of each row only refill the shift register.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            line0_q[col_q] <= i_pixel;
            line1_q[col_q] <= rd0;
        end
    end

`ifdef CONV_FEEDER_FRAME_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_frame_cnt <= '0;
        end else if (o_valid && o_last && i_ready) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder on a 4x4 image with an image-array reference model.
module tb_conv_window_feeder;

    localparam int DW = 4;
    localparam int W  = 4;
    localparam int H  = 4;

    typedef logic [0:2][0:2][DW-1:0] win_t;
    typedef struct packed {
        win_t win;
        logic last;
    } exp_t;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_pixel;
    logic          o_valid;
    logic          i_ready;
    win_t          o_window;
    logic          o_last;
`ifdef CONV_FEEDER_FRAME_CNT_EN
    logic [15:0]   o_frame_cnt;
`endif

    conv_window_feeder #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_pixel  (i_pixel),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_window (o_window),
        .o_last   (o_last)
`ifdef CONV_FEEDER_FRAME_CNT_EN
        ,
        .o_frame_cnt (o_frame_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_win    = 0;
    int            n_last   = 0;
    int            mr       = 0;
    int            mc       = 0;
    int            fcnt     = 0;
    logic [DW-1:0] img [0:H-1][0:W-1];
    exp_t          q [$];
    win_t          seen [$];
    win_t          tab [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model at the falling edge, advance the model.
    task automatic step(input logic v, input logic [DW-1:0] px, input logic rdy, output bit acc);
        exp_t e;
        win_t w;
        i_valid = v;
        i_pixel = px;
        i_ready = rdy;
        @(negedge i_clk);
        chk("o_valid", 64'(o_valid), 64'(q.size() != 0));
        chk("o_ready", 64'(o_ready), 64'((q.size() == 0) || rdy));
        if (q.size() != 0) begin
            chk("o_window", 64'(o_window), 64'(q[0].win));
            chk("o_last", 64'(o_last), 64'(q[0].last));
        end
`ifdef CONV_FEEDER_FRAME_CNT_EN
        chk("o_frame_cnt", 64'(o_frame_cnt), 64'(fcnt[15:0]));
`endif
        acc = v && ((q.size() == 0) || rdy);
        if (q.size() != 0 && rdy) begin
            if (q[0].last) begin
                n_last++;
                fcnt++;
            end
            seen.push_back(o_window);
            void'(q.pop_front());
            n_win++;
        end
        if (acc) begin
            img[mr][mc] = px;
            if (mr >= 2 && mc >= 2) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        w[i][j] = img[mr-2+i][mc-2+j];
                e.win  = w;
                e.last = (mr == H - 1) && (mc == W - 1);
                q.push_back(e);
            end
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] px, input bit rand_rdy);
        bit   acc;
        int   tries;
        logic rdy;
        acc   = 0;
        tries = 0;
        while (!acc && tries < 64) begin
            rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rand_rdy && $urandom_range(0, 4) == 0) step(1'b0, DW'($urandom), rdy, acc);
            else step(1'b1, px, rdy, acc);
            tries++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 3; k++) step(1'b0, DW'($urandom), 1'b1, acc);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        q.delete();
        mr   = 0;
        mc   = 0;
        fcnt = 0;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_last", 64'(o_last), 64'd0);
        chk("rst_o_window", 64'(o_window), 64'd0);
        chk("rst_o_ready", 64'(o_ready), 64'd1);
`ifdef CONV_FEEDER_FRAME_CNT_EN
        chk("rst_o_frame_cnt", 64'(o_frame_cnt), 64'd0);
`endif
    endtask

    task automatic check_basic(input int start, input int count);
        for (int k = 0; k < count; k++) begin
            if (start + k < seen.size()) chk("basic_window", 64'(seen[start+k]), 64'(tab[k % 4]));
            else chk("basic_window_missing", 64'd0, 64'd1);
        end
    endtask

    initial begin
        bit acc;
        int base_win;
        int base_last;

        tab[0] = 36'h01245689A;
        tab[1] = 36'h1235679AB;
        tab[2] = 36'h45689ACDE;
        tab[3] = 36'h5679ABDEF;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_pixel = '0;
        do_reset();

        // Basic frame 0..15 with the downstream always ready.
        seen.delete();
        base_win  = n_win;
        base_last = n_last;
        for (int p = 0; p < 16; p++) send(DW'(p), 1'b0);
        drain();
        chk("basic_count", 64'(n_win - base_win), 64'd4);
        chk("basic_last_count", 64'(n_last - base_last), 64'd1);
        check_basic(0, 4);

        // Backpressure: hold i_ready low for five cycles once the first window appears.
        seen.delete();
        base_win = n_win;
        for (int p = 0; p < 11; p++) send(DW'(p), 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, DW'(11), 1'b0, acc);
            chk("bp_no_accept", 64'(acc), 64'd0);
        end
        for (int p = 11; p < 16; p++) send(DW'(p), 1'b0);
        drain();
        chk("bp_count", 64'(n_win - base_win), 64'd4);
        check_basic(0, 4);

        // Two frames back to back.
        seen.delete();
        base_win  = n_win;
        base_last = n_last;
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 16; p++) send(DW'(p), 1'b0);
        drain();
        chk("b2b_count", 64'(n_win - base_win), 64'd8);
        chk("b2b_last_count", 64'(n_last - base_last), 64'd2);
        check_basic(0, 8);

        // Reset after pixel 7, then a fresh frame.
        for (int p = 0; p < 8; p++) send(DW'(p), 1'b0);
        do_reset();
        seen.delete();
        base_win = n_win;
        for (int p = 0; p < 16; p++) send(DW'(p), 1'b0);
        drain();
        chk("post_reset_count", 64'(n_win - base_win), 64'd4);
        check_basic(0, 4);

        // Three random frames with random idles and stalls.
        do_reset();
        base_win = n_win;
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < W * H; p++) send(DW'($urandom), 1'b1);
        drain();
        chk("rand_count", 64'(n_win - base_win), 64'(3 * (W - 2) * (H - 2)));
`ifdef CONV_FEEDER_FRAME_CNT_EN
        chk("frame_cnt_3", 64'(o_frame_cnt), 64'd3);
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
